// File: rtl/mem_arbiter_if.sv
// Bundles the fetch, data and shared-memory port signals of the two-requester memory arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface mem_arbiter_if;
  logic        ifu_req_i;
  logic [31:0] ifu_addr_i;
  logic        ifu_gnt_o;
  logic        ifu_rvalid_o;
  logic [31:0] ifu_rdata_o;

  logic        lsu_req_i;
  logic        lsu_wen_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_wdata_i;
  logic [3:0]  lsu_wmask_i;
  logic        lsu_gnt_o;
  logic        lsu_rvalid_o;
  logic [31:0] lsu_rdata_o;

  logic        mem_req_o;
  logic        mem_wen_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wmask_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  logic        err_timeout_o;

  modport slave (
    input  ifu_req_i, ifu_addr_i,
    output ifu_gnt_o, ifu_rvalid_o, ifu_rdata_o,
    input  lsu_req_i, lsu_wen_i, lsu_addr_i, lsu_wdata_i, lsu_wmask_i,
    output lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o,
    output mem_req_o, mem_wen_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output err_timeout_o
  );

  modport master (
    output ifu_req_i, ifu_addr_i,
    input  ifu_gnt_o, ifu_rvalid_o, ifu_rdata_o,
    output lsu_req_i, lsu_wen_i, lsu_addr_i, lsu_wdata_i, lsu_wmask_i,
    input  lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o,
    input  mem_req_o, mem_wen_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  err_timeout_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch (IFU) and load/store (LSU) requesters,
// one outstanding transaction at a time, LSU priority with IFU starvation guard and timeout abort.
module mem_arbiter #(
  parameter int MAX_SKIP = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  mem_arbiter_if.slave  bus
);
  localparam int SW = $clog2(MAX_SKIP + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] SKIP_MAX = SW'(MAX_SKIP);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  state_e        state_q, state_d;
  logic          owner_ifu_q, owner_ifu_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wmask_q, wmask_d;
  logic          wen_q, wen_d;
  logic [SW-1:0] skip_q, skip_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          rvalid_q, rvalid_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          ifu_gnt, lsu_gnt;
  logic          force_ifu;
  logic          mem_req;

  assign force_ifu = bus.ifu_req_i && (skip_q == SKIP_MAX);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      owner_ifu_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      wen_q       <= 1'b0;
      skip_q      <= '0;
      tmo_q       <= '0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_ifu_q <= owner_ifu_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      wen_q       <= wen_d;
      skip_q      <= skip_d;
      tmo_q       <= tmo_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_ifu_d = owner_ifu_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    wen_d       = wen_q;
    skip_d      = skip_q;
    tmo_d       = tmo_q;
    rvalid_d    = 1'b0;
    rdata_d     = '0;
    err_d       = 1'b0;
    ifu_gnt     = 1'b0;
    lsu_gnt     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.lsu_req_i && !force_ifu) begin
          lsu_gnt     = 1'b1;
          owner_ifu_d = 1'b0;
          addr_d      = bus.lsu_addr_i;
          wdata_d     = bus.lsu_wdata_i;
          wmask_d     = bus.lsu_wmask_i;
          wen_d       = bus.lsu_wen_i;
          tmo_d       = '0;
          state_d     = REQ;
          if (bus.ifu_req_i && (skip_q != SKIP_MAX)) skip_d = skip_q + 1'b1;
        end else if (bus.ifu_req_i) begin
          ifu_gnt     = 1'b1;
          owner_ifu_d = 1'b1;
          addr_d      = bus.ifu_addr_i;
          wdata_d     = '0;
          wmask_d     = '0;
          wen_d       = 1'b0;
          tmo_d       = '0;
          skip_d      = '0;
          state_d     = REQ;
        end
      end
      REQ: begin
        tmo_d = tmo_q + 1'b1;
        // A response arriving with the grant completes the transaction without visiting RESP.
        if (bus.mem_gnt_i && bus.mem_rvalid_i) begin
          rvalid_d = 1'b1;
          rdata_d  = bus.mem_rdata_i;
          state_d  = IDLE;
        end else if (bus.mem_gnt_i) begin
          state_d = RESP;
        end else if (tmo_q == TMO_LAST) begin
          rvalid_d = 1'b1;
          err_d    = 1'b1;
          state_d  = IDLE;
        end
      end
      RESP: begin
        tmo_d = tmo_q + 1'b1;
        if (bus.mem_rvalid_i) begin
          rvalid_d = 1'b1;
          rdata_d  = bus.mem_rdata_i;
          state_d  = IDLE;
        end else if (tmo_q == TMO_LAST) begin
          rvalid_d = 1'b1;
          err_d    = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Grants are combinational from the request, so gate them while reset is held.
  assign bus.ifu_gnt_o = ifu_gnt & rst_n_i;
  assign bus.lsu_gnt_o = lsu_gnt & rst_n_i;

  assign mem_req         = (state_q == REQ);
  assign bus.mem_req_o   = mem_req;
  assign bus.mem_wen_o   = mem_req & wen_q;
  assign bus.mem_addr_o  = mem_req ? addr_q  : '0;
  assign bus.mem_wdata_o = mem_req ? wdata_q : '0;
  assign bus.mem_wmask_o = mem_req ? wmask_q : '0;

  assign bus.ifu_rvalid_o  = rvalid_q & owner_ifu_q;
  assign bus.lsu_rvalid_o  = rvalid_q & ~owner_ifu_q;
  assign bus.ifu_rdata_o   = bus.ifu_rvalid_o ? rdata_q : '0;
  assign bus.lsu_rdata_o   = bus.lsu_rvalid_o ? rdata_q : '0;
  assign bus.err_timeout_o = err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected grants, payloads and responses;
// a negedge monitor pops and compares whenever the arbiter presents them.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if bus();
  mem_arbiter dut (.clk_i(clk), .rst_n_i(rst_n), .bus(bus));

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic [31:0] lat;
  } rsp_t;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic        wen;
  } pay_t;

  rsp_t ifu_q[$];
  rsp_t lsu_q[$];
  pay_t pay_q[$];
  bit   gnt_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int rv_cnt = 0;
  int mreq_cnt = 0;
  int gnt_cnt = 0;
  int ifu_gcyc = 0;
  int lsu_gcyc = 0;
  int mem_mode = 0;
  logic [31:0] mem_rsp = '0;
  int stray_req = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Memory model: grants in the first REQ cycle; mode 0 answers next cycle,
  // mode 1 answers with the grant, mode 2 never answers.
  initial begin
    bit pend;
    int stray_done;
    pend = 1'b0;
    stray_done = 0;
    bus.mem_gnt_i = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      bus.mem_gnt_i = 1'b0;
      bus.mem_rvalid_i = 1'b0;
      bus.mem_rdata_i = '0;
      if (!rst_n) begin
        pend = 1'b0;
      end else if (stray_req != stray_done) begin
        stray_done++;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i = 32'hDEAD_BEEF;
      end else if (pend) begin
        pend = 1'b0;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i = mem_rsp;
      end else if (bus.mem_req_o) begin
        bus.mem_gnt_i = 1'b1;
        if (mem_mode == 1) begin
          bus.mem_rvalid_i = 1'b1;
          bus.mem_rdata_i = mem_rsp;
        end else if (mem_mode == 0) begin
          pend = 1'b1;
        end
      end
    end
  end

  // Monitor: responses are handled before grants so a back-to-back grant does not
  // overwrite the grant cycle of the transaction being answered.
  initial begin
    rsp_t r;
    pay_t p;
    bit   e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.ifu_rvalid_o) begin
          rv_cnt++;
          if (ifu_q.size() == 0) check("ifu_unexpected_rvalid", bus.ifu_rvalid_o, 0);
          else begin
            r = ifu_q.pop_front();
            check("ifu_rdata", bus.ifu_rdata_o, r.data);
            check("ifu_err", bus.err_timeout_o, r.err);
            check("ifu_latency", cyc - ifu_gcyc, r.lat);
          end
        end else if (bus.ifu_rdata_o != 0) check("ifu_rdata_without_rvalid", bus.ifu_rdata_o, 0);
        if (bus.lsu_rvalid_o) begin
          rv_cnt++;
          if (lsu_q.size() == 0) check("lsu_unexpected_rvalid", bus.lsu_rvalid_o, 0);
          else begin
            r = lsu_q.pop_front();
            check("lsu_rdata", bus.lsu_rdata_o, r.data);
            check("lsu_err", bus.err_timeout_o, r.err);
            check("lsu_latency", cyc - lsu_gcyc, r.lat);
          end
        end else if (bus.lsu_rdata_o != 0) check("lsu_rdata_without_rvalid", bus.lsu_rdata_o, 0);
        if (bus.err_timeout_o && !bus.ifu_rvalid_o && !bus.lsu_rvalid_o)
          check("err_without_rvalid", bus.err_timeout_o, 0);
        if (bus.mem_req_o) begin
          mreq_cnt++;
          if (pay_q.size() == 0) check("unexpected_mem_req", bus.mem_req_o, 0);
          else begin
            p = pay_q.pop_front();
            check("mem_payload", {bus.mem_addr_o, bus.mem_wdata_o, bus.mem_wmask_o, bus.mem_wen_o}, p);
          end
        end
        if (bus.ifu_gnt_o || bus.lsu_gnt_o) begin
          gnt_cnt++;
          if (gnt_q.size() == 0) check("unexpected_gnt", {bus.ifu_gnt_o, bus.lsu_gnt_o}, 0);
          else begin
            e = gnt_q.pop_front();
            check("gnt_owner", {bus.ifu_gnt_o, bus.lsu_gnt_o}, e ? 2'b10 : 2'b01);
          end
          if (bus.ifu_gnt_o) ifu_gcyc = cyc;
          if (bus.lsu_gnt_o) lsu_gcyc = cyc;
        end
      end
    end
  end

  function automatic logic [159:0] all_outputs();
    return {bus.ifu_gnt_o, bus.ifu_rvalid_o, bus.ifu_rdata_o, bus.lsu_gnt_o, bus.lsu_rvalid_o,
            bus.lsu_rdata_o, bus.mem_req_o, bus.mem_wen_o, bus.mem_addr_o, bus.mem_wdata_o,
            bus.mem_wmask_o, bus.err_timeout_o};
  endfunction

  task automatic expect_xact(input bit ifu, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] mask, input bit wen, input logic [31:0] rsp,
                             input int mode, input bit has_rsp);
    pay_t p;
    rsp_t r;
    gnt_q.push_back(ifu);
    p.addr  = addr;
    p.wdata = ifu ? 32'h0 : wdata;
    p.mask  = ifu ? 4'h0 : mask;
    p.wen   = ifu ? 1'b0 : wen;
    pay_q.push_back(p);
    if (has_rsp) begin
      r.data = (mode == 2) ? 32'h0 : rsp;
      r.err  = (mode == 2);
      r.lat  = (mode == 0) ? 3 : (mode == 1) ? 2 : 256;
      if (ifu) ifu_q.push_back(r);
      else lsu_q.push_back(r);
    end
  endtask

  task automatic xact(input bit ifu, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] mask, input bit wen, input logic [31:0] rsp,
                      input int mode, input bit has_rsp);
    bit got;
    mem_mode = mode;
    mem_rsp  = rsp;
    expect_xact(ifu, addr, wdata, mask, wen, rsp, mode, has_rsp);
    bus.lsu_wdata_i = wdata;
    bus.lsu_wmask_i = mask;
    bus.lsu_wen_i   = wen;
    if (ifu) begin
      bus.ifu_req_i = 1'b1;
      bus.ifu_addr_i = addr;
    end else begin
      bus.lsu_req_i = 1'b1;
      bus.lsu_addr_i = addr;
    end
    got = 1'b0;
    for (int i = 0; i < 1000 && !got; i++) begin
      @(negedge clk);
      got = ifu ? bus.ifu_gnt_o : bus.lsu_gnt_o;
    end
    if (!got) check("gnt_wait", got, 1);
    @(posedge clk);
    #1;
    bus.ifu_req_i = 1'b0;
    bus.lsu_req_i = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && (ifu_q.size() + lsu_q.size()) != 0; i++) @(posedge clk);
    check("drain", ifu_q.size() + lsu_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int n;
    int c_first;
    int c_last;
    int rv_before;
    bus.ifu_req_i = 1'b0;
    bus.ifu_addr_i = '0;
    bus.lsu_req_i = 1'b0;
    bus.lsu_wen_i = 1'b0;
    bus.lsu_addr_i = '0;
    bus.lsu_wdata_i = '0;
    bus.lsu_wmask_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", all_outputs(), 0);
    rst_n = 1'b1;

    // Fetch with zero-wait memory; stale LSU payload must not leak onto the port.
    xact(1'b1, 32'h8000_0000, 32'h1111_2222, 4'hF, 1'b1, 32'h0000_0413, 0, 1'b1);
    drain();

    // LSU load with grant and response in the same cycle.
    xact(1'b0, 32'h8000_0100, 32'h0, 4'h0, 1'b0, 32'hCAFE_F00D, 1, 1'b1);
    drain();

    // LSU store with normal memory timing.
    xact(1'b0, 32'h8000_0204, 32'h5A5A_1234, 4'b0011, 1'b1, 32'h0000_0001, 0, 1'b1);
    drain();

    // Contention: both requesters held; IFU must win the fifth arbitration, then LSU again.
    mem_mode = 0;
    mem_rsp  = 32'h0000_0077;
    for (int k = 0; k < 6; k++)
      expect_xact(k == 4, (k == 4) ? 32'h8000_0004 : 32'h8000_1002, 32'hA5A5_0000, 4'b1100,
                  1'b1, 32'h0000_0077, 0, 1'b1);
    bus.ifu_req_i = 1'b1;
    bus.ifu_addr_i = 32'h8000_0004;
    bus.lsu_req_i = 1'b1;
    bus.lsu_addr_i = 32'h8000_1002;
    bus.lsu_wdata_i = 32'hA5A5_0000;
    bus.lsu_wmask_i = 4'b1100;
    bus.lsu_wen_i = 1'b1;
    n = 0;
    c_first = 0;
    c_last = 0;
    for (int i = 0; i < 200 && n < 6; i++) begin
      @(negedge clk);
      if (bus.ifu_gnt_o || bus.lsu_gnt_o) begin
        if (n == 0) c_first = cyc;
        c_last = cyc;
        n++;
      end
    end
    @(posedge clk);
    #1;
    bus.ifu_req_i = 1'b0;
    bus.lsu_req_i = 1'b0;
    check("contend_grants", n, 6);
    check("b2b_period", c_last - c_first, 15);
    drain();

    // Stray memory response while idle must produce no rvalid.
    rv_before = rv_cnt;
    stray_req++;
    repeat (4) @(posedge clk);
    #1;
    check("stray_rvalid", rv_cnt - rv_before, 0);

    // Memory never responds: timeout abort after 255 cycles in REQ/RESP.
    xact(1'b1, 32'h8000_0300, 32'h0, 4'h0, 1'b0, 32'hFFFF_FFFF, 2, 1'b1);
    drain();

    // Reset while in RESP: transaction discarded, outputs zero during reset.
    xact(1'b0, 32'h8000_0400, 32'h0, 4'h0, 1'b0, 32'h0, 2, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.lsu_req_i = 1'b1;
    bus.lsu_addr_i = 32'h8000_0500;
    bus.lsu_wen_i = 1'b0;
    #2;
    check("reset_mid_outputs", all_outputs(), 0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    xact(1'b0, 32'h8000_0500, 32'h0, 4'h0, 1'b0, 32'h1357_9BDF, 0, 1'b1);
    drain();
    repeat (5) @(posedge clk);
    #1;

    check("mem_req_cycles", mreq_cnt, gnt_cnt);
    check("gnt_queue_empty", gnt_q.size(), 0);
    check("payload_queue_empty", pay_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
